// File: rtl/gate_tt_sequencer_if.sv
// Stimulus/result bundle between the truth-table sequencer,
// the gate under test and whoever launches runs.
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail;

  modport master (
    input  start,
    input  dut_y,
    output dut_in,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail
  );

  modport slave (
    output start,
    output dut_y,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Walks a gate through its full truth table, compares each
// sampled output with EXPECTED and reports errors/first failure.
module gate_tt_sequencer #(
  parameter int                  N_IN        = 2,
  parameter int                  HOLD_CYCLES = 2,
  parameter logic [2**N_IN-1:0]  EXPECTED    = 4'b0111
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_tt_sequencer_if.master bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        // dut_y is judged only at the edge closing a vector's hold window
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (bus.dut_y != EXPECTED[vec_q]) begin
            err_d = err_q + (N_IN+1)'(1);
            if (err_q == '0) ff_d = vec_q;
          end
          if (&vec_q) begin
            state_d = S_DONE;
            vec_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dut_in     = vec_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule
